// File: rtl/n4_sar_controller.sv
`default_nettype none
// ============================================================================
// Module   : n4_sar_controller
// Purpose  : 4-bit successive-approximation controller. It drives a trial
//            value into an external combinational comparator and resolves the
//            unknown operand one bit per cycle, MSB first, from the returned
//            eq/gr/lr flags.
// Ports    : clock    - single clock, rising edge
//            reset_   - synchronous active-low reset
//            start    - request a new search (sampled only in IDLE)
//            flag_eq  - comparator: x == y3_y0
//            flag_gr  - comparator: x >  y3_y0
//            flag_lr  - comparator: x <  y3_y0
//            y3_y0    - registered trial value to the comparator
//            r3_r0    - resolved value, valid with done, held until next start
//            busy     - high while testing bits
//            done     - one-cycle completion pulse
//            err      - illegal/inconsistent flags seen, held until next start
// Revision : 1.0 - initial release
// ============================================================================
module n4_sar_controller (
  input  logic       clock,
  input  logic       reset_,
  input  logic       start,
  input  logic       flag_eq,
  input  logic       flag_gr,
  input  logic       flag_lr,
  output logic [3:0] y3_y0,
  output logic [3:0] r3_r0,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TEST = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] k, k_nxt;
  logic [3:0] y_nxt;
  logic [3:0] r_nxt;
  logic       err_nxt;

  logic [2:0] flags;
  logic [3:0] bit_k;      // bit currently under test
  logic [3:0] bit_below;  // next bit to try (only meaningful when k > 0)
  logic [3:0] prefix;     // trial value with the tested bit cleared

  assign flags     = {flag_eq, flag_gr, flag_lr};
  assign bit_k     = 4'b0001 << k;
  assign bit_below = 4'b0001 << (k - 2'd1);
  assign prefix    = y3_y0 & ~bit_k;

  // Status outputs come straight from the state register.
  assign busy = (state == TEST);
  assign done = (state == DONE);

  always_ff @(posedge clock) begin
    if (!reset_) begin
      state <= IDLE;
      k     <= 2'd3;
      y3_y0 <= 4'b0000;
      r3_r0 <= 4'b0000;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      y3_y0 <= y_nxt;
      r3_r0 <= r_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    y_nxt     = y3_y0;
    r_nxt     = r3_r0;
    err_nxt   = err;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = TEST;
          k_nxt     = 2'd3;
          y_nxt     = 4'b1000;
          r_nxt     = 4'b0000;
          err_nxt   = 1'b0;
        end
      end

      TEST: begin
        unique case (flags)
          3'b100: begin
            // Exact match: no further bits need testing.
            r_nxt     = y3_y0;
            state_nxt = DONE;
          end
          3'b010: begin
            if (k != 2'd0) begin
              y_nxt = y3_y0 | bit_below;
              k_nxt = k - 2'd1;
            end else begin
              // x above the all-ones-below trial contradicts earlier eq miss.
              err_nxt   = 1'b1;
              r_nxt     = y3_y0;
              state_nxt = DONE;
            end
          end
          3'b001: begin
            if (k != 2'd0) begin
              y_nxt = prefix | bit_below;
              k_nxt = k - 2'd1;
            end else begin
              r_nxt     = prefix;
              state_nxt = DONE;
            end
          end
          default: begin
            // None set, or more than one set.
            err_nxt   = 1'b1;
            r_nxt     = y3_y0;
            state_nxt = DONE;
          end
        endcase
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_n4_sar_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_n4_sar_controller
// Purpose  : Self-checking bench for n4_sar_controller. A behavioural
//            comparator answers the trial value against a chosen unknown,
//            with an override to inject illegal flag patterns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_n4_sar_controller;

  logic       clock;
  logic       reset_;
  logic       start;
  logic       flag_eq, flag_gr, flag_lr;
  logic [3:0] y3_y0, r3_r0;
  logic       busy, done, err;

  logic [3:0] x_val;
  logic       ovr_en;
  logic [2:0] ovr_flags;   // {eq, gr, lr}

  int n_checks = 0;
  int n_fail   = 0;

  n4_sar_controller dut (
    .clock   (clock),
    .reset_  (reset_),
    .start   (start),
    .flag_eq (flag_eq),
    .flag_gr (flag_gr),
    .flag_lr (flag_lr),
    .y3_y0   (y3_y0),
    .r3_r0   (r3_r0),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural comparator with injection override.
  always_comb begin
    if (ovr_en) begin
      {flag_eq, flag_gr, flag_lr} = ovr_flags;
    end else begin
      flag_eq = (x_val == y3_y0);
      flag_gr = (x_val >  y3_y0);
      flag_lr = (x_val <  y3_y0);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  x;
    int          inj_mode;   // 0 none, 1 flags=000, 2 force gr, 3 flags=110
    int          inj_trial;  // trial index receiving the injection
    bit          pulse;      // hold start high during TEST and DONE
    logic [3:0]  exp_r;
    logic        exp_err;
    int          exp_lat;    // cycles from start cycle to done cycle
    int          exp_nt;     // number of trials presented
    logic [15:0] exp_tr;     // trial 0 in [15:12], trial 1 in [11:8], ...
  } vec_t;

  vec_t       vecs [11];
  logic [3:0] trials [8];
  int         nt, lat;
  logic [3:0] got_r;
  logic       got_e;

  // Starts a search from IDLE at a falling edge and follows it to DONE.
  task automatic run_search(input logic [3:0] x, input int inj_mode,
                            input int inj_trial, input bit pulse);
    x_val = x;
    start = 1'b1;
    @(negedge clock);
    start = pulse;
    nt    = 0;
    lat   = -1;
    got_r = 4'hx;
    got_e = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      check("busy_and_done_exclusive", int'(busy & done), 0);
      if (i == 1) begin
        check("r_cleared_on_start", int'(r3_r0), 0);
        check("err_cleared_on_start", int'(err), 0);
      end
      if (done) begin
        lat   = i;
        got_r = r3_r0;
        got_e = err;
        break;
      end
      if (busy) begin
        if (nt < 8) trials[nt] = y3_y0;
        if (inj_mode != 0 && nt == inj_trial) begin
          ovr_en    = 1'b1;
          ovr_flags = (inj_mode == 1) ? 3'b000 :
                      (inj_mode == 2) ? 3'b010 : 3'b110;
        end
        nt++;
      end
      @(negedge clock);
      ovr_en = 1'b0;
    end
    start = 1'b0;
    @(negedge clock);
    check("idle_after_done_busy", int'(busy), 0);
    check("idle_after_done_done", int'(done), 0);
    check("r_held_in_idle", int'(r3_r0), int'(got_r));
  endtask

  initial begin
    vecs[0]  = '{4'b1011, 0, 0, 0, 4'b1011, 1'b0, 5, 4, 16'b1000_1100_1010_1011};
    vecs[1]  = '{4'b1000, 0, 0, 0, 4'b1000, 1'b0, 2, 1, 16'b1000_0000_0000_0000};
    vecs[2]  = '{4'b0000, 0, 0, 0, 4'b0000, 1'b0, 5, 4, 16'b1000_0100_0010_0001};
    vecs[3]  = '{4'b1111, 0, 0, 0, 4'b1111, 1'b0, 5, 4, 16'b1000_1100_1110_1111};
    vecs[4]  = '{4'b0001, 0, 0, 0, 4'b0001, 1'b0, 5, 4, 16'b1000_0100_0010_0001};
    vecs[5]  = '{4'b0110, 0, 0, 0, 4'b0110, 1'b0, 4, 3, 16'b1000_0100_0110_0000};
    vecs[6]  = '{4'b1011, 1, 1, 0, 4'b1100, 1'b1, 3, 2, 16'b1000_1100_0000_0000};
    vecs[7]  = '{4'b0000, 2, 3, 0, 4'b0001, 1'b1, 5, 4, 16'b1000_0100_0010_0001};
    vecs[8]  = '{4'b0111, 0, 0, 1, 4'b0111, 1'b0, 5, 4, 16'b1000_0100_0110_0111};
    vecs[9]  = '{4'b1010, 0, 0, 1, 4'b1010, 1'b0, 4, 3, 16'b1000_1100_1010_0000};
    vecs[10] = '{4'b0101, 3, 0, 0, 4'b1000, 1'b1, 2, 1, 16'b1000_0000_0000_0000};

    reset_    = 1'b0;
    start     = 1'b0;
    x_val     = 4'b0000;
    ovr_en    = 1'b0;
    ovr_flags = 3'b000;
    repeat (2) @(negedge clock);
    check("reset_y", int'(y3_y0), 0);
    check("reset_r", int'(r3_r0), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    reset_ = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_hold_busy", int'(busy), 0);

    // Back-to-back table searches.
    for (int v = 0; v < 11; v++) begin
      run_search(vecs[v].x, vecs[v].inj_mode, vecs[v].inj_trial, vecs[v].pulse);
      check($sformatf("v%0d_latency", v), lat, vecs[v].exp_lat);
      check($sformatf("v%0d_result", v), int'(got_r), int'(vecs[v].exp_r));
      check($sformatf("v%0d_err", v), int'(got_e), int'(vecs[v].exp_err));
      check($sformatf("v%0d_trials", v), nt, vecs[v].exp_nt);
      for (int t = 0; t < vecs[v].exp_nt && t < nt; t++) begin
        logic [15:0] tr;
        tr = vecs[v].exp_tr;
        check($sformatf("v%0d_trial%0d", v, t), int'(trials[t]),
              int'(tr[15 - 4*t -: 4]));
      end
    end

    // Reset during the third TEST cycle of a search for 1011.
    x_val = 4'b1011;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("mid_third_trial_busy", int'(busy), 1);
    check("mid_third_trial_y", int'(y3_y0), 4'b1010);
    reset_ = 1'b0;
    @(negedge clock);
    check("midreset_y", int'(y3_y0), 0);
    check("midreset_r", int'(r3_r0), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_err", int'(err), 0);
    reset_ = 1'b1;
    repeat (2) @(negedge clock);
    check("post_reset_idle", int'(busy | done), 0);

    // A fresh search after the interrupted one starts again from bit 3.
    run_search(4'b1101, 0, 0, 0);
    check("after_reset_latency", lat, 5);
    check("after_reset_result", int'(got_r), 4'b1101);
    check("after_reset_err", int'(got_e), 0);
    check("after_reset_trial1", int'(trials[1]), 4'b1100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/n4_sar_controller.md
# n4_sar_controller

Sequential 4-bit successive-approximation controller. It is the initiator side of the 4-bit comparator interface. It drives a trial operand `y3_y0` into an external combinational comparator whose other operand is an unknown `x3_x0`, reads back `flag_eq`/`flag_gr`/`flag_lr`, and resolves `x3_x0` one bit per cycle, MSB first. It sits beside the comparator/subtractor datapath and is used to recover a value that is observable only through comparison.

## Interface
- No parameters (width fixed at 4).
- `clock`  in  1  single clock; all state updates on rising edge.
- `reset_`  in  1  synchronous, active-low reset.
- `start`  in  1  request a new search; sampled only in IDLE.
- `flag_eq`  in  1  comparator: `x3_x0 == y3_y0`.
- `flag_gr`  in  1  comparator: `x3_x0 > y3_y0`.
- `flag_lr`  in  1  comparator: `x3_x0 < y3_y0`.
- `y3_y0`  out  4  registered trial value driven to the comparator.
- `r3_r0`  out  4  resolved value; valid when `done`=1, held until the next accepted `start`.
- `busy`  out  1  high in TEST.
- `done`  out  1  one-cycle pulse in DONE.
- `err`  out  1  set with `done` when the flags were illegal or inconsistent; held until the next accepted `start`.

## Operation
- States: IDLE, TEST, DONE. A 2-bit index `k` selects the bit under test (3 down to 0).
- Reset (`reset_`=0 at an edge), from any state and mid-search included:
  - state goes to IDLE;
  - `y3_y0`=0000, `r3_r0`=0000, `busy`=0, `done`=0, `err`=0, `k`=3.
- IDLE, `start`=1:
  - go to TEST with `k`=3 and `y3_y0`=1000;
  - clear `r3_r0` and `err`.
- IDLE, `start`=0: hold all state.
- TEST: flags are sampled against the current `y3_y0`. Let `p` = `y3_y0` with bit `k` cleared (the prefix decided so far).
  - Flags not one-hot (none set, or more than one set): `err`=1, `r3_r0`=`y3_y0`, go to DONE.
  - `flag_eq`: `r3_r0`=`y3_y0`, go to DONE. This is an early exit.
  - `flag_gr`, `k`>0: keep bit `k`. Next `y3_y0` = `y3_y0` | (1<<(k-1)); `k`=`k`-1.
  - `flag_lr`, `k`>0: clear bit `k`. Next `y3_y0` = `p` | (1<<(k-1)); `k`=`k`-1.
  - `flag_lr`, `k`=0: `r3_r0`=`p`, go to DONE.
  - `flag_gr`, `k`=0: this contradicts the earlier decisions. `err`=1, `r3_r0`=`y3_y0`, go to DONE.
- DONE:
  - `done`=1 for exactly one cycle, then go to IDLE;
  - `y3_y0` holds its last trial value;
  - `start` is ignored in DONE.
- `start` is ignored while in TEST; a search cannot be aborted except by reset.
- All arithmetic is 4-bit unsigned. No carries are formed; bits are only set or cleared.

## Timing
- `y3_y0` is registered. The comparator is combinational, so flags for a trial value are valid in the same cycle that value is presented, and are sampled at the next edge.
- Edge E0: `start` accepted. From E0+1, `busy`=1 and `y3_y0`=1000.
- Each TEST cycle resolves one bit. There are at most 4 TEST cycles.
- Latency from accepting `start` to `done`:
  - from E0+2 (eq on the first trial) to E0+5 (all four bits tested);
  - `done` and `busy` are never high together.
- Earliest next accepted `start` is the edge after `done` (IDLE).
- Outputs `busy`/`done` are decoded from registered state; there are no combinational paths from inputs to outputs.

## Test plan
- `x3_x0`=1011: trials 1000(gr), 1100(lr), 1010(gr), 1011(eq). Required: `r3_r0`=1011, `err`=0, `done` at E0+5.
- `x3_x0`=1000: first trial 1000 gives eq. Required: `r3_r0`=1000, `done` at E0+2, only one trial presented.
- `x3_x0`=0000: trials 1000, 0100, 0010, 0001, all lr. Required: `r3_r0`=0000, `err`=0, `done` at E0+5.
- `x3_x0`=1111 and 0001: `x3_x0`=1111 gives trials 1000, 1100, 1110, 1111 with `r3_r0`=1111. `x3_x0`=0001 gives `r3_r0`=0001 via eq on the 4th trial.
- Illegal flags:
  - force flags=000 on the 2nd trial: required `err`=1 and `done` one cycle later;
  - force gr on trial 0001: required `err`=1.
- Reset and `start` handling:
  - `reset_`=0 during the 3rd TEST cycle: next cycle IDLE with all outputs at reset values;
  - `start` pulses during TEST and DONE are ignored;
  - back-to-back searches with different `x3_x0` give correct, independent results.
